// File: rtl/or1200_cpu_mem_bfm_pkg.sv
// Shared definitions for the OR1200 CPU memory responder.
// Holds the per-port FSM encoding, the wait-counter width and the default error window.
// No logic lives here, so it adds no latency and has no backpressure of its own.
package or1200_cpu_mem_bfm_pkg;

    // Per-port access state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_e;

    // The wait counter holds WAIT-1, and WAIT is in 0..15.
    localparam int unsigned CNT_W = 4;

    // Default bus-error window: the top 4 KiB page of the address space.
    localparam logic [31:0] DEF_ERR_BASE = 32'hFFFF_F000;
    localparam logic [31:0] DEF_ERR_MASK = 32'hFFFF_F000;

endpackage

// File: rtl/or1200_cpu_mem_port_fsm.sv
// Per-port access timer: IDLE -> (WAIT x N) -> RESP, with a one-cycle ack or err.
// Latency: the response is high in cycle WAIT+1 after cycstb is first sampled high.
// Backpressure: none. Dropping cycstb during WAIT aborts the access, and o_resp_fire never asserts.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   i_cycstb     : bus request from the CPU port
//   i_addr_err   : current address is in the error window or out of range
//   o_resp_ack   : registered ack, high during RESP when the access was good
//   o_resp_err   : registered err, high during RESP when the access was bad
//   o_resp_fire  : commit strobe on the edge that enters RESP. The top captures read data and
//                  performs the write on this edge, so the data is valid together with ack.
module or1200_cpu_mem_port_fsm
    import or1200_cpu_mem_bfm_pkg::*;
#(
    parameter int unsigned WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cycstb,
    input  logic i_addr_err,
    output logic o_resp_ack,
    output logic o_resp_err,
    output logic o_resp_fire
);

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

    port_state_e      r_state;
    port_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cycstb) begin
                    if (WAIT == 0) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = i_addr_err;
                        w_fire      = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_cycstb) begin
                    // The master gave up, so go back to IDLE silently.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = i_addr_err;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A reset in the commit cycle must also cancel the write and the data capture.
    assign o_resp_fire = w_fire && !rst;
    assign o_resp_ack  = (r_state == ST_RESP) && !r_err;
    assign o_resp_err  = (r_state == ST_RESP) &&  r_err;

endmodule

// File: rtl/or1200_cpu_mem_bfm.sv
// Dual-port (icpu/dcpu) word memory responder with a side-band program loader.
// Latency: ack or err arrives IWAIT+1 or DWAIT+1 cycles after the request. Read data is valid with ack.
// Backpressure: none. A request that drops during its wait is aborted without a response or a write.
//
// Ports:
//   clk, rst                         : clock and synchronous active-high reset (the loader ignores reset)
//   icpu_adr/cycstb/sel_i            : instruction fetch request (sel is ignored, full-word read)
//   icpu_dat/ack/err/rty_o           : instruction response (rty is tied to 0)
//   dcpu_adr/cycstb/we/sel/dat_i     : data request with byte-lane write enables
//   dcpu_dat/ack/err/rty_o           : data response (rty is tied to 0)
//   ld_we/adr/dat_i                  : loader word write. It has priority over a dcpu write to the same word.
module or1200_cpu_mem_bfm
    import or1200_cpu_mem_bfm_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned IWAIT    = 1,
    parameter int unsigned DWAIT    = 2,
    parameter logic [31:0] ERR_BASE = DEF_ERR_BASE,
    parameter logic [31:0] ERR_MASK = DEF_ERR_MASK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   icpu_adr_i,
    input  logic          icpu_cycstb_i,
    input  logic [3:0]    icpu_sel_i,
    output logic [31:0]   icpu_dat_o,
    output logic          icpu_ack_o,
    output logic          icpu_err_o,
    output logic          icpu_rty_o,
    input  logic [31:0]   dcpu_adr_i,
    input  logic          dcpu_cycstb_i,
    input  logic          dcpu_we_i,
    input  logic [3:0]    dcpu_sel_i,
    input  logic [31:0]   dcpu_dat_i,
    output logic [31:0]   dcpu_dat_o,
    output logic          dcpu_ack_o,
    output logic          dcpu_err_o,
    output logic          dcpu_rty_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_adr_i,
    input  logic [31:0]   ld_dat_i
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [31:0]   r_idat;
    logic [31:0]   r_ddat;

    logic [AW-1:0] w_iidx;
    logic [AW-1:0] w_didx;
    logic          w_ierr;
    logic          w_derr;
    logic          w_ifire;
    logic          w_dfire;
    logic          w_dwr;
    logic          w_ld_hit;
    logic          w_unused;

    // Byte offsets are ignored, and any address bit above the array is a bus error.
    assign w_iidx = icpu_adr_i[AW+1:2];
    assign w_didx = dcpu_adr_i[AW+1:2];
    assign w_ierr = ((icpu_adr_i & ERR_MASK) == ERR_BASE) || ((icpu_adr_i >> (AW + 2)) != 32'd0);
    assign w_derr = ((dcpu_adr_i & ERR_MASK) == ERR_BASE) || ((dcpu_adr_i >> (AW + 2)) != 32'd0);

    or1200_cpu_mem_port_fsm #(.WAIT(IWAIT)) u_ifsm (
        .clk         (clk),
        .rst         (rst),
        .i_cycstb    (icpu_cycstb_i),
        .i_addr_err  (w_ierr),
        .o_resp_ack  (icpu_ack_o),
        .o_resp_err  (icpu_err_o),
        .o_resp_fire (w_ifire)
    );

    or1200_cpu_mem_port_fsm #(.WAIT(DWAIT)) u_dfsm (
        .clk         (clk),
        .rst         (rst),
        .i_cycstb    (dcpu_cycstb_i),
        .i_addr_err  (w_derr),
        .o_resp_ack  (dcpu_ack_o),
        .o_resp_err  (dcpu_err_o),
        .o_resp_fire (w_dfire)
    );

    assign w_dwr    = w_dfire && dcpu_we_i && !w_derr;
    assign w_ld_hit = ld_we_i && (ld_adr_i == w_didx);

    // The array has no reset, so the loader can fill it while the CPU is held in reset.
    always_ff @(posedge clk) begin
        if (w_dwr && !w_ld_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (dcpu_sel_i[b]) begin
                    r_mem[w_didx][8*b +: 8] <= dcpu_dat_i[8*b +: 8];
                end
            end
        end
        if (ld_we_i) begin
            r_mem[ld_adr_i] <= ld_dat_i;
        end
    end

    // Reads sample the array before this edge's writes, so a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idat <= '0;
            r_ddat <= '0;
        end else begin
            if (w_ifire && !w_ierr) begin
                r_idat <= r_mem[w_iidx];
            end
            if (w_dfire && !dcpu_we_i && !w_derr) begin
                r_ddat <= r_mem[w_didx];
            end
        end
    end

    assign icpu_dat_o = r_idat;
    assign dcpu_dat_o = r_ddat;
    assign icpu_rty_o = 1'b0;
    assign dcpu_rty_o = 1'b0;

    // Instruction fetches are always full-word reads.
    assign w_unused = ^icpu_sel_i;

endmodule
